button_conditioner: RTL and testbench

- Parametrised front end that turns raw, bouncy button or switch lines into clean key events for the calculator core.
- Per channel: synchroniser, debounce filter, press/release edge pulses.
- Shared auto-repeat timer, plus a priority encoder that produces a key code.
- Sits between board pins and the calculator core, in the single fast clock domain. Supersedes ad-hoc direct mapping of switch levels.

---
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_conditioner.sv | 123 ++++++++++++
 tb/tb_button_conditioner.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Key-event bundle between raw board lines and the calculator core.
// The master side drives raw levels; the slave side is the conditioner.
interface button_conditioner_if #(
  parameter int NUM_BUTTONS = 16,
  parameter int CODE_W      = $clog2(NUM_BUTTONS)
);
  logic [NUM_BUTTONS-1:0] raw_i;
  logic [NUM_BUTTONS-1:0] held_o;
  logic [NUM_BUTTONS-1:0] press_o;
  logic [NUM_BUTTONS-1:0] release_o;
  logic                   code_valid_o;
  logic [CODE_W-1:0]      code_o;
  logic                   multi_o;

  modport master (
    output raw_i,
    input  held_o, press_o, release_o, code_valid_o, code_o, multi_o
  );

  modport slave (
    input  raw_i,
    output held_o, press_o, release_o, code_valid_o, code_o, multi_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Button front end: per-channel synchroniser and debounce, press/release pulses,
// shared single-key auto-repeat timer and a lowest-index-wins key encoder.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CODE_W          = $clog2(NUM_BUTTONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  button_conditioner_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RTMR_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RTMR_W-1:0] DLY_LAST = RTMR_W'(REPEAT_DELAY - 1);
  localparam logic [RTMR_W-1:0] PER_LAST = RTMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic {
    PH_DELAY,
    PH_REPEAT
  } phase_e;

  logic [SYNC_STAGES-1:0][NUM_BUTTONS-1:0] sync_q;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]                  held_q, held_d;
  logic [NUM_BUTTONS-1:0]                  press_q, press_d;
  logic [NUM_BUTTONS-1:0]                  release_q, release_d;
  logic                                    valid_q, valid_d;
  logic [CODE_W-1:0]                       code_q, code_d;
  logic                                    multi_q, multi_d;
  logic [RTMR_W-1:0]                       rtmr_q, rtmr_d;
  phase_e                                  phase_q, phase_d;
  logic                                    rep_fire;
  logic [NUM_BUTTONS-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      rtmr_q    <= '0;
      phase_q   <= PH_DELAY;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.raw_i};
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      rtmr_q    <= rtmr_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    held_d   = held_q;
    cnt_d    = cnt_q;
    rtmr_d   = rtmr_q;
    phase_d  = phase_q;
    rep_fire = 1'b0;
    code_d   = '0;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (s[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        held_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    multi_d = |(held_d & (held_d - NUM_BUTTONS'(1)));

    // Any change, chord or idle reloads the timer so a fresh single hold waits the full delay.
    if ((REPEAT_EN == 0) || (held_d != held_q) || (held_d == '0) || multi_d) begin
      rtmr_d  = '0;
      phase_d = PH_DELAY;
    end else if ((phase_q == PH_DELAY) && (rtmr_q == DLY_LAST)) begin
      rep_fire = 1'b1;
      rtmr_d   = '0;
      phase_d  = PH_REPEAT;
    end else if ((phase_q == PH_REPEAT) && (rtmr_q == PER_LAST)) begin
      rep_fire = 1'b1;
      rtmr_d   = '0;
    end else begin
      rtmr_d = rtmr_q + RTMR_W'(1);
    end

    press_d   = (held_d & ~held_q) | (rep_fire ? held_d : '0);
    release_d = held_q & ~held_d;
    valid_d   = |press_d;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (press_d[i]) code_d = CODE_W'(i);
    end
  end

  assign bus.held_o       = held_q;
  assign bus.press_o      = press_q;
  assign bus.release_o    = release_q;
  assign bus.code_valid_o = valid_q;
  assign bus.code_o       = code_q;
  assign bus.multi_o      = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, directed multi-cycle sequences and
// randomized bouncy stimulus checked against a window/age based reference model.
module tb_button_conditioner;

  localparam int NB   = 16;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int DLY  = 10;
  localparam int PER  = 3;

  typedef struct packed {
    logic [SYNC-1:0][NB-1:0] pipe;
    logic [DC-1:0][NB-1:0]   hist;
    logic [NB-1:0]           held;
    logic [NB-1:0]           press;
    logic [NB-1:0]           rel;
    logic [3:0]              code;
    logic                    valid;
    logic                    multi;
    int unsigned             age;
  } model_t;

  typedef struct packed {
    logic [NB-1:0] raw;
    int            reps;
    logic [NB-1:0] held;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [3:0]    code;
    logic          valid;
    logic          multi;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] raw = '0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  model_t        mdl_r = '0;
  model_t        mdl_n = '0;
  int            pr_cyc[$];
  logic [NB-1:0] pr_val[$];
  logic [3:0]    pr_code[$];
  int            rl_cyc[$];
  logic [NB-1:0] rl_val[$];
  int            np_cnt = 0;
  vec_t          vecs[$];

  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BUTTONS(NB)) bus_r ();
  button_conditioner_if #(.NUM_BUTTONS(NB)) bus_n ();
  assign bus_r.raw_i = raw;
  assign bus_n.raw_i = raw;

  button_conditioner #(
    .NUM_BUTTONS(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC),
    .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut_r (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_r)
  );

  button_conditioner #(
    .NUM_BUTTONS(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC),
    .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut_n (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_n)
  );

  // A level flips once the last DC synchronised samples all disagree with it;
  // repeats fire when a single key has been stable for DLY + m*PER edges.
  function automatic model_t model_next(model_t m, logic rn, logic [NB-1:0] r, bit rep_en);
    model_t        n;
    logic [NB-1:0] s_used;
    logic [NB-1:0] flip;
    bit            fire;
    n = m;
    if (!rn) begin
      n = '0;
      return n;
    end
    s_used = m.pipe[SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) n.pipe[k] = m.pipe[k-1];
    n.pipe[0] = r;
    for (int k = DC - 1; k > 0; k--) n.hist[k] = m.hist[k-1];
    n.hist[0] = s_used;
    flip = '1;
    for (int k = 0; k < DC; k++) flip &= (n.hist[k] ^ m.held);
    n.held = m.held ^ flip;
    if ((n.held == m.held) && ($countones(n.held) == 1)) n.age = m.age + 1;
    else n.age = 0;
    fire = rep_en && (n.age >= DLY) && (((n.age - DLY) % PER) == 0);
    n.press = (n.held & ~m.held) | (fire ? n.held : '0);
    n.rel   = m.held & ~n.held;
    n.valid = |n.press;
    n.code  = '0;
    for (int i = NB - 1; i >= 0; i--) if (n.press[i]) n.code = 4'(i);
    n.multi = $countones(n.held) > 1;
    return n;
  endfunction

  function automatic logic [63:0] pack_exp(model_t m);
    return {10'b0, m.held, m.press, m.rel, m.code, m.valid, m.multi};
  endfunction

  function automatic logic [63:0] obs_r();
    return {10'b0, bus_r.held_o, bus_r.press_o, bus_r.release_o,
            bus_r.code_o, bus_r.code_valid_o, bus_r.multi_o};
  endfunction

  function automatic logic [63:0] obs_n();
    return {10'b0, bus_n.held_o, bus_n.press_o, bus_n.release_o,
            bus_n.code_o, bus_n.code_valid_o, bus_n.multi_o};
  endfunction

  function automatic vec_t mk(logic [NB-1:0] r, int reps, logic [NB-1:0] h, logic [NB-1:0] p,
                              logic [NB-1:0] rl, logic [3:0] c, logic v, logic mu);
    vec_t x;
    x.raw = r; x.reps = reps; x.held = h; x.press = p;
    x.rel = rl; x.code = c; x.valid = v; x.multi = mu;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    mdl_r = model_next(mdl_r, rst_n, raw, 1'b1);
    mdl_n = model_next(mdl_n, rst_n, raw, 1'b0);
    cyc++;
    #1;
    checkOutput($sformatf("model_rep@%0d", cyc), obs_r(), pack_exp(mdl_r));
    checkOutput($sformatf("model_norep@%0d", cyc), obs_n(), pack_exp(mdl_n));
    if (bus_r.press_o != '0) begin
      pr_cyc.push_back(cyc);
      pr_val.push_back(bus_r.press_o);
      pr_code.push_back(bus_r.code_o);
    end
    if (bus_r.release_o != '0) begin
      rl_cyc.push_back(cyc);
      rl_val.push_back(bus_r.release_o);
    end
    if (bus_n.press_o != '0) np_cnt++;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] r, input int until_edge);
    raw = r;
    while (cyc < until_edge) step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    raw   = '0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
    pr_cyc.delete(); pr_val.delete(); pr_code.delete();
    rl_cyc.delete(); rl_val.delete();
    np_cnt = 0;
  endtask

  initial begin
    logic [NB-1:0] bp [5];
    int            exp_cyc [8];
    logic [NB-1:0] target;
    int            len;

    // Clean press/release of bit 5, then a two-key chord of bits 2 and 9.
    vecs.push_back(mk(16'h0020, 5, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0020, 1, 16'h0020, 16'h0020, 16'h0000, 4'd5, 1'b1, 1'b0));
    vecs.push_back(mk(16'h0020, 1, 16'h0020, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0000, 5, 16'h0020, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0000, 1, 16'h0000, 16'h0000, 16'h0020, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0204, 5, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0204, 1, 16'h0204, 16'h0204, 16'h0000, 4'd2, 1'b1, 1'b1));
    vecs.push_back(mk(16'h0204, 3, 16'h0204, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(16'h0000, 5, 16'h0204, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(16'h0000, 1, 16'h0000, 16'h0000, 16'h0204, 4'd0, 1'b0, 1'b0));

    reset_dut();
    checkOutput("reset_state", obs_r(), 64'd0);
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        raw = vecs[v].raw;
        step();
        checkOutput($sformatf("vec%0d", v), obs_r(),
                    {10'b0, vecs[v].held, vecs[v].press, vecs[v].rel,
                     vecs[v].code, vecs[v].valid, vecs[v].multi});
      end
    end

    // Bounce on bit 3: one press, 5 edges after the final rise is sampled.
    reset_dut();
    bp[0] = 16'h0008; bp[1] = 16'h0000; bp[2] = 16'h0008; bp[3] = 16'h0000; bp[4] = 16'h0008;
    for (int k = 0; k < 5; k++) applyStimulus(bp[k], k + 1);
    applyStimulus(16'h0008, 15);
    checkOutput("bounce_press_count", 64'(pr_cyc.size()), 64'd1);
    checkOutput("bounce_press_edge", 64'((pr_cyc.size() > 0) ? pr_cyc[0] : -1), 64'd10);
    checkOutput("bounce_release_count", 64'(rl_cyc.size()), 64'd0);

    // Auto-repeat of bit 7 held for 30 cycles after acceptance.
    reset_dut();
    exp_cyc = '{6, 16, 19, 22, 25, 28, 31, 34};
    applyStimulus(16'h0080, 36);
    checkOutput("repeat_count", 64'(pr_cyc.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("repeat_edge%0d", i),
                  64'((pr_cyc.size() > i) ? pr_cyc[i] : -1), 64'(exp_cyc[i]));
      checkOutput($sformatf("repeat_code%0d", i),
                  64'((pr_code.size() > i) ? pr_code[i] : 4'hf), 64'd7);
    end
    checkOutput("repeat_off_count", 64'(np_cnt), 64'd1);

    // Chord suppresses repeat; dropping to one key reloads the full delay.
    reset_dut();
    applyStimulus(16'h0204, 30);
    applyStimulus(16'h0200, 47);
    checkOutput("chord_press_count", 64'(pr_cyc.size()), 64'd2);
    checkOutput("chord_first", 64'((pr_val.size() > 0) ? pr_val[0] : '0), 64'h0204);
    checkOutput("chord_repeat_edge", 64'((pr_cyc.size() > 1) ? pr_cyc[1] : -1), 64'd46);
    checkOutput("chord_repeat_code", 64'((pr_code.size() > 1) ? pr_code[1] : 4'hf), 64'd9);
    checkOutput("chord_release_edge", 64'((rl_cyc.size() > 0) ? rl_cyc[0] : -1), 64'd36);
    checkOutput("chord_release_val", 64'((rl_val.size() > 0) ? rl_val[0] : '0), 64'h0004);
    checkOutput("chord_multi_end", 64'(bus_r.multi_o), 64'd0);

    // Reset while bit 4 is held: silent clear, then a fresh press 6 edges later.
    reset_dut();
    applyStimulus(16'h0010, 10);
    rst_n = 1'b0;
    step();
    checkOutput("midreset_clear", obs_r(), 64'd0);
    rst_n = 1'b1;
    cyc   = 0;
    applyStimulus(16'h0010, 8);
    checkOutput("midreset_press_count", 64'(pr_cyc.size()), 64'd2);
    checkOutput("midreset_repress_edge", 64'((pr_cyc.size() > 1) ? pr_cyc[1] : -1), 64'd6);
    checkOutput("midreset_release_count", 64'(rl_cyc.size()), 64'd0);

    // Without auto-repeat a long hold of bit 1 gives exactly one press.
    reset_dut();
    applyStimulus(16'h0002, 56);
    checkOutput("norepeat_count", 64'(np_cnt), 64'd1);

    // Randomized bouncy segments with occasional resets.
    reset_dut();
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 3))
        0:       target = '0;
        3:       target = (NB'(1) << $urandom_range(0, NB - 1)) | (NB'(1) << $urandom_range(0, NB - 1));
        default: target = NB'(1) << $urandom_range(0, NB - 1);
      endcase
      len = $urandom_range(3, 40);
      for (int c = 0; c < len; c++) begin
        if (c < 4) raw = target ^ (NB'($urandom) & (raw ^ target));
        else raw = target;
        rst_n = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
